// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO: direction, synchronised inputs, atomic set/clear,
// sticky rising-edge interrupt status with level irq output.
module gpio_ctrl #(
  parameter int unsigned           WIDTH       = 6,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter logic [3:0]            BASE        = 4'h9,
  parameter logic [WIDTH-1:0]      RESET_OUT   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [3:0]       wen,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] din_d_q;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] ien_q, ien_d;
  logic [WIDTH-1:0] stat_q, stat_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             sel, wr, rd;
  logic [2:0]       idx;
  logic [WIDTH-1:0] din, rise, lane_m, wd, w1c;
  logic             unused_ok;

  assign sel  = en && (addr[31:28] == BASE);
  assign wr   = sel && (wen != 4'b0);
  assign rd   = sel && (wen == 4'b0);
  assign idx  = addr[4:2];
  assign wd   = wdata[WIDTH-1:0];
  assign din  = sync_q[SYNC_STAGES-1];
  assign rise = din & ~din_d_q;

  assign unused_ok = ^{addr[27:5], addr[1:0], wdata, wen};

  always_comb begin
    lane_m = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      lane_m[i] = wen[i/8];
    end
  end

  always_comb begin
    dout_d  = dout_q;
    dir_d   = dir_q;
    ien_d   = ien_q;
    w1c     = '0;
    rdata_d = '0;
    if (wr) begin
      case (idx)
        3'd0: dout_d = (dout_q & ~lane_m) | (wd & lane_m);
        3'd1: dir_d  = (dir_q & ~lane_m) | (wd & lane_m);
        3'd3: dout_d = dout_q | (wd & lane_m);
        3'd4: dout_d = dout_q & ~(wd & lane_m);
        3'd5: ien_d  = (ien_q & ~lane_m) | (wd & lane_m);
        3'd6: w1c    = wd & lane_m;
        default: ;
      endcase
    end
    // a same-cycle rising edge beats the W1C clear
    stat_d = (stat_q & ~w1c) | rise;
    if (rd) begin
      case (idx)
        3'd0: rdata_d = 32'(dout_q);
        3'd1: rdata_d = 32'(dir_q);
        3'd2: rdata_d = 32'(din);
        3'd5: rdata_d = 32'(ien_q);
        3'd6: rdata_d = 32'(stat_q);
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= '0;
      end
      din_d_q <= '0;
      dout_q  <= RESET_OUT;
      dir_q   <= '0;
      ien_q   <= '0;
      stat_q  <= '0;
      rdata_q <= '0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int s = 1; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      din_d_q <= din;
      dout_q  <= dout_d;
      dir_q   <= dir_d;
      ien_q   <= ien_d;
      stat_q  <= stat_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata   = rdata_q;
  assign gpio_o  = dout_q;
  assign gpio_oe = dir_q;
  assign irq     = |(stat_q & ien_q);

endmodule

// File: tb/tb_gpio_ctrl.sv
// Bench for gpio_ctrl: per-cycle rdata scoreboard plus direct
// checks of gpio_o, gpio_oe and irq.
module tb_gpio_ctrl;

  localparam int W = 6;
  localparam logic [31:0] B = 32'h9000_0000;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          en;
  logic [3:0]    wen;
  logic [31:0]   addr, wdata, rdata;
  logic [W-1:0]  gpio_i, gpio_o, gpio_oe;
  logic          irq;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];

  gpio_ctrl #(
    .WIDTH(W), .SYNC_STAGES(2),
    .BASE(4'h9), .RESET_OUT(6'h2A)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .en(en), .wen(wen), .addr(addr),
    .wdata(wdata), .rdata(rdata),
    .gpio_i(gpio_i), .gpio_o(gpio_o),
    .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // One bus cycle; expected rdata of the following cycle is queued.
  task automatic acc(input string tag,
                     input logic e, input logic [3:0] w,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd);
    logic [31:0] e_rd;
    en = e; wen = w; addr = a; wdata = d;
    exp_q.push_back(exp_rd);
    @(posedge clk); #1;
    e_rd = exp_q.pop_front();
    chk(tag, rdata, e_rd);
    en = 1'b0; wen = 4'h0; addr = '0; wdata = '0;
  endtask

  task automatic idle(input string tag);
    acc(tag, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b0; wen = '0;
    addr = '0; wdata = '0; gpio_i = '0;
    #12;
    chk("rst_gpio_o", 32'(gpio_o), 32'h2A);
    chk("rst_oe", 32'(gpio_oe), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    acc("rd_dout_rst", 1, 4'h0, B, 0, 32'h2A);
    acc("wr_dout", 1, 4'hF, B, 32'h0F, 0);
    chk("gpio_o_0F", 32'(gpio_o), 32'h0F);
    acc("wr_set", 1, 4'hF, B + 32'h0C, 32'h30, 0);
    chk("gpio_o_3F", 32'(gpio_o), 32'h3F);
    acc("wr_clr", 1, 4'hF, B + 32'h10, 32'h03, 0);
    chk("gpio_o_3C", 32'(gpio_o), 32'h3C);
    acc("rd_set", 1, 4'h0, B + 32'h0C, 0, 0);
    acc("rd_clr", 1, 4'h0, B + 32'h10, 0, 0);
    acc("wen0_read", 1, 4'h0, B, 32'hFF, 32'h3C);
    chk("wen0_noop", 32'(gpio_o), 32'h3C);
    acc("hi_lanes", 1, 4'hE, B, 32'h0, 0);
    chk("hi_lanes_noop", 32'(gpio_o), 32'h3C);
    acc("wr_din_ro", 1, 4'hF, B + 32'h08, 32'h3F, 0);

    acc("wr_dir", 1, 4'hF, B + 32'h04, 32'hFFFF_FFFF, 0);
    chk("oe_3F", 32'(gpio_oe), 32'h3F);
    acc("rd_dir", 1, 4'h0, B + 32'h04, 0, 32'h3F);
    acc("oob_wr", 1, 4'hF, 32'h0000_0004, 0, 0);
    chk("oob_oe", 32'(gpio_oe), 32'h3F);
    acc("oob_rd", 1, 4'h0, 32'h0000_0004, 0, 0);
    acc("rd_rsvd", 1, 4'h0, B + 32'h1C, 0, 0);

    acc("wr_ien", 1, 4'hF, B + 32'h14, 32'h08, 0);
    acc("rd_ien", 1, 4'h0, B + 32'h14, 0, 32'h08);

    gpio_i = 6'h08;
    idle("edge_n");
    chk("irq_n", 32'(irq), 0);
    acc("din_n1", 1, 4'h0, B + 32'h08, 0, 0);
    chk("irq_n1", 32'(irq), 0);
    acc("stat_n2", 1, 4'h0, B + 32'h18, 0, 0);
    chk("irq_n2", 32'(irq), 1);
    acc("din_n3", 1, 4'h0, B + 32'h08, 0, 32'h08);
    acc("stat_set", 1, 4'h0, B + 32'h18, 0, 32'h08);
    acc("w1c", 1, 4'hF, B + 32'h18, 32'h08, 0);
    chk("irq_w1c", 32'(irq), 0);
    acc("stat_clr", 1, 4'h0, B + 32'h18, 0, 0);

    gpio_i = 6'h00;
    idle("fall0"); idle("fall1"); idle("fall2");
    chk("irq_fall", 32'(irq), 0);
    acc("stat_fall", 1, 4'h0, B + 32'h18, 0, 0);

    gpio_i = 6'h08;
    idle("rise_m");
    idle("rise_m1");
    acc("w1c_race", 1, 4'hF, B + 32'h18, 32'h08, 0);
    chk("irq_race", 32'(irq), 1);
    acc("stat_race", 1, 4'h0, B + 32'h18, 0, 32'h08);
    gpio_i = 6'h00;
    idle("f0"); idle("f1"); idle("f2");
    chk("irq_keep", 32'(irq), 1);
    acc("stat_keep", 1, 4'h0, B + 32'h18, 0, 32'h08);

    acc("ien_all", 1, 4'hF, B + 32'h14, 32'h3F, 0);
    gpio_i = 6'h3F;
    idle("a0"); idle("a1"); idle("a2");
    acc("stat_3F", 1, 4'h0, B + 32'h18, 0, 32'h3F);
    acc("dout_15", 1, 4'hF, B, 32'h15, 0);
    chk("gpio_o_15", 32'(gpio_o), 32'h15);

    en = 1'b1; wen = 4'h0; addr = B;
    #3 reset_n = 1'b0;
    #1;
    chk("arst_gpio_o", 32'(gpio_o), 32'h2A);
    chk("arst_oe", 32'(gpio_oe), 0);
    chk("arst_irq", 32'(irq), 0);
    chk("arst_rdata", rdata, 0);
    @(posedge clk); #1;
    chk("arst_hold", rdata, 0);
    en = 1'b0; addr = '0;
    gpio_i = 6'h00;
    reset_n = 1'b1;
    acc("post_stat", 1, 4'h0, B + 32'h18, 0, 0);
    acc("post_ien", 1, 4'h0, B + 32'h14, 0, 0);
    acc("post_dout", 1, 4'h0, B, 0, 32'h2A);
    idle("post_idle");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gpio_ctrl.md
# gpio_ctrl

Parametrised memory-mapped GPIO controller. It replaces the fixed 6-bit output-only GPIO register in the CPU top. It sits on the data-memory port beside `dtcm`, decodes its own region (`addr[31:28] == BASE`), and provides:
- per-bit direction control,
- synchronised inputs,
- atomic set/clear,
- sticky rising-edge interrupt status with a level interrupt output.

## Interface
- `WIDTH`, default 6: number of GPIO bits, 1..32. Register bits above WIDTH read 0 and ignore writes.
- `SYNC_STAGES`, default 2: input synchroniser depth, 2..4.
- `BASE`, default 4'h9: value of `addr[31:28]` that selects this block.
- `RESET_OUT`, default 0: reset value of DATA_OUT, WIDTH bits.

Ports:
- `clk`  in  1  sole clock; all flops on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  bus access strobe.
- `wen`  in  4  byte write enables; `wen == 0` with `en` is a read.
- `addr`  in  32  byte address; `[31:28]` selects the block, `[4:2]` selects the register.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data, registered.
- `gpio_i`  in  WIDTH  asynchronous pin inputs.
- `gpio_o`  out  WIDTH  output values (DATA_OUT).
- `gpio_oe`  out  WIDTH  output enables (DIR, 1 = drive).
- `irq`  out  1  level interrupt, `|(IRQ_STAT & IRQ_EN)`.

## Operation
Selection: `sel = en && addr[31:28] == BASE`. Write when `sel && wen != 0`; read when `sel && wen == 0`.

Byte lanes: `wen[k]` qualifies bits `8k+7:8k` of every writable register. Lanes beyond WIDTH have no effect.

Register map (offset, by `addr[4:2]`):
- 0x00 DATA_OUT: RW; drives `gpio_o`.
- 0x04 DIR: RW; drives `gpio_oe`.
- 0x08 DATA_IN: RO; last synchroniser stage. Writes ignored.
- 0x0C SET: WO; `DATA_OUT |= wdata` per lane. Reads 0.
- 0x10 CLR: WO; `DATA_OUT &= ~wdata` per lane. Reads 0.
- 0x14 IRQ_EN: RW.
- 0x18 IRQ_STAT: RW1C. Bit set on rising edge of the synchronised input; writing 1 clears it.
- 0x1C: reserved; reads 0, writes ignored.

Input path and edge detection:
- `gpio_i` passes through a SYNC_STAGES flop chain to give `din`.
- A `din_d` register holds the previous `din`.
- Rising edge: `rise = din & ~din_d`.
- `rise` is detected for every bit regardless of DIR and IRQ_EN.

Simultaneous events:
- `rise` and a W1C clear on the same bit in the same cycle: the set wins; the bit stays 1.
- Read-back of DATA_OUT, DIR, IRQ_EN and IRQ_STAT returns the value before the same-cycle write.
- Any access outside the block's region does not change `rdata`'s zero default (see Timing).

Reset (`reset_n` low, asynchronous, any cycle including mid-access):
- DATA_OUT = RESET_OUT; DIR = 0; IRQ_EN = 0; IRQ_STAT = 0.
- Synchroniser and `din_d` = 0, so no spurious edge comes from reset values alone.
- `rdata` = 0; `irq` = 0.
- Any in-flight read is dropped.

## Timing
- Write: takes effect at the `clk` edge where it is presented. `gpio_o`, `gpio_oe` and `irq` update immediately after that edge.
- Read: `rdata` is valid the cycle after the `sel` read cycle, matching `dtcm` latency. In every other cycle `rdata` = 0, so the top ORs or muxes it without a select.
- Back-to-back accesses: one per cycle, no stall.
- Input change before edge N:
  - visible in DATA_IN after edge N+SYNC_STAGES-1;
  - IRQ_STAT set after edge N+SYNC_STAGES;
  - `irq` asserts the same cycle if enabled.
- `irq` is combinational from flops only; it has no path from bus inputs.

## Test plan
- Reset with RESET_OUT=6'h2A, WIDTH=6 -> `gpio_o`=2A, `gpio_oe`=0, `irq`=0, `rdata`=0. Read 0x00 -> next cycle `rdata`=0x2A.
- Write DATA_OUT=0x0F, SET 0x30, CLR 0x03 -> `gpio_o` = 0x0F, then 0x3F, then 0x3C. Reading SET or CLR returns 0. Write with `wen`=0 but `en`=1 is a read and does not modify state.
- Write 0xFFFFFFFF to DIR -> `gpio_oe`=0x3F and readback=0x3F. Access with `addr[31:28]`=0 -> no state change, `rdata`=0.
- SYNC_STAGES=2: raise `gpio_i[3]` before edge 10 -> DATA_IN bit3 reads 1 after edge 11; IRQ_STAT=0x08 after edge 12. With IRQ_EN=0x08, `irq`=1 after edge 12. Write 0x08 to IRQ_STAT -> `irq`=0 next cycle.
- A new rising edge on bit 3 coinciding with a W1C of bit 3 -> bit stays 1 and `irq` stays high. Falling edge -> no status change.
- Assert `reset_n` low asynchronously mid-cycle with IRQ_STAT=0x3F and DATA_OUT set -> all outputs return to reset values immediately, before the next `clk` edge.
